// File: rtl/card_disp_pkg.sv
// Shared types and glyph constants for the card display scanner.
package card_disp_pkg;

  typedef enum logic [1:0] {
    HEX   = 2'b00,
    SUIT  = 2'b01,
    RANK  = 2'b10,
    BLANK = 2'b11
  } mode_e;

  localparam int unsigned DIGIT_W = 6;

  // Active-high {g,f,e,d,c,b,a} glyphs
  localparam logic [6:0] SUIT_DIAMOND = 7'b1011110;
  localparam logic [6:0] SUIT_HEART   = 7'b1110100;
  localparam logic [6:0] SUIT_CLUB    = 7'b1011000;
  localparam logic [6:0] SUIT_SPADE   = 7'b1101101;
  localparam logic [6:0] RANK_ACE     = 7'b1110111;
  localparam logic [6:0] RANK_TEN     = 7'b0111111;
  localparam logic [6:0] RANK_JACK    = 7'b0011110;
  localparam logic [6:0] RANK_QUEEN   = 7'b1100111;
  localparam logic [6:0] RANK_KING    = 7'b1110110;
  localparam logic [6:0] RANK_DASH    = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK  = 7'b0000000;

  // Digit word that renders blank: mode 11, value 0
  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 6'b11_0000;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    g = GLYPH_BLANK;
    unique case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/glyph_decode.sv
// Combinational {mode, value} -> active-high gfedcba glyph.
module glyph_decode
  import card_disp_pkg::*;
(
  input  mode_e       mode,
  input  logic [3:0]  value,
  output logic [6:0]  glyph
);

  // Decode the glyph for the selected mode
  always_comb begin
    glyph = GLYPH_BLANK;
    unique case (mode)
      HEX:  glyph = hex_glyph(value);
      SUIT: begin
        unique case (value[1:0])
          2'b00: glyph = SUIT_DIAMOND;
          2'b01: glyph = SUIT_HEART;
          2'b10: glyph = SUIT_CLUB;
          2'b11: glyph = SUIT_SPADE;
        endcase
      end
      RANK: begin
        case (value)
          4'd1:                                        glyph = RANK_ACE;
          4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: glyph = hex_glyph(value);
          4'd10:                                       glyph = RANK_TEN;
          4'd11:                                       glyph = RANK_JACK;
          4'd12:                                       glyph = RANK_QUEEN;
          4'd13:                                       glyph = RANK_KING;
          default:                                     glyph = RANK_DASH;
        endcase
      end
      BLANK: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/card_display_scan.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffer, blink and dead time.
module card_display_scan
  import card_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned DEAD_CYCLES    = 500,
  parameter int unsigned BLINK_FRAMES   = 250
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]         blink_in,
  input  logic                          load_in,
  output logic [6:0]                    cat_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic                          frame_done
);

  localparam int unsigned SlotW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned BufW   = DIGIT_W * NUM_DIGITS;

  logic [SlotW-1:0]      slot_q, slot_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [BlinkW-1:0]     bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic [BufW-1:0]       pend_q, pend_d, act_q, act_d;
  logic [NUM_DIGITS-1:0] pblk_q, pblk_d, ablk_q, ablk_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            cat_q, cat_d;
  logic                  fd_q;

  logic                  slot_wrap, boundary;
  logic [DIGIT_W-1:0]    cur_digit;
  logic                  cur_blink;
  logic [6:0]            cur_glyph;

  assign slot_wrap = (slot_q == SlotW'(REFRESH_CYCLES - 1));
  assign boundary  = slot_wrap && (idx_q == IdxW'(NUM_DIGITS - 1));

  // Select the active digit word and blink bit for the current index
  always_comb begin
    cur_digit = BLANK_DIGIT;
    cur_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_digit = act_q[i*DIGIT_W +: DIGIT_W];
        cur_blink = ablk_q[i];
      end
    end
  end

  glyph_decode u_glyph_decode (
    .mode  (mode_e'(cur_digit[5:4])),
    .value (cur_digit[3:0]),
    .glyph (cur_glyph)
  );

  // Next-state for counters, buffers and output registers
  always_comb begin
    slot_d  = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    pend_d  = load_in ? data_in : pend_q;
    pblk_d  = load_in ? blink_in : pblk_q;
    act_d   = act_q;
    ablk_d  = ablk_q;
    if (slot_wrap) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end
    if (boundary) begin
      // A load landing on the boundary bypasses pending so it shows this frame
      act_d  = load_in ? data_in : pend_q;
      ablk_d = load_in ? blink_in : pblk_q;
      if (bcnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    an_d  = (slot_q < SlotW'(DEAD_CYCLES)) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    cat_d = (cur_blink && phase_q) ? 7'h7F : ~cur_glyph;
  end

  // State and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot_q  <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      pend_q  <= {NUM_DIGITS{BLANK_DIGIT}};
      act_q   <= {NUM_DIGITS{BLANK_DIGIT}};
      pblk_q  <= '0;
      ablk_q  <= '0;
      an_q    <= '1;
      cat_q   <= '1;
      fd_q    <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      pblk_q  <= pblk_d;
      ablk_q  <= ablk_d;
      an_q    <= an_d;
      cat_q   <= cat_d;
      fd_q    <= boundary;
    end
  end

  assign an_out     = an_q;
  assign cat_out    = cat_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_card_display_scan.sv
// Directed bench for card_display_scan with N=4, REFRESH=8, DEAD=2, BLINK=2.
module tb_card_display_scan;

  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data;
  logic [3:0]  blink;
  logic        load;
  logic [6:0]  cat;
  logic [3:0]  an;
  logic        fd;

  int errors = 0;
  int checks = 0;

  // Expected-behaviour state: slot, index, blink frame count, phase, buffered glyphs
  int         ms, mi, mf;
  logic       mp;
  logic [6:0] act_cat[4];
  logic [6:0] pend_cat[4];
  logic [6:0] ld_cat[4];
  logic [3:0] act_blk, pend_blk;

  always #5 clk = ~clk;

  card_display_scan #(
    .NUM_DIGITS     (N),
    .REFRESH_CYCLES (R),
    .DEAD_CYCLES    (D),
    .BLINK_FRAMES   (B)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .data_in    (data),
    .blink_in   (blink),
    .load_in    (load),
    .cat_out    (cat),
    .an_out     (an),
    .frame_done (fd)
  );

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; mi = 0; mf = 0; mp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      act_cat[i]  = 7'h7F;
      pend_cat[i] = 7'h7F;
    end
    act_blk  = 4'b0;
    pend_blk = 4'b0;
  endtask

  // One clock: predict outputs from the pre-edge state, then check at the falling edge
  task automatic cyc();
    logic [3:0] e_an;
    logic [6:0] e_cat;
    logic       bnd;
    @(posedge clk);
    e_an  = (ms < D) ? 4'hF : ~(4'b0001 << mi);
    e_cat = (act_blk[mi] && mp) ? 7'h7F : act_cat[mi];
    bnd   = (ms == R - 1) && (mi == N - 1);
    if (bnd) begin
      for (int i = 0; i < 4; i++) act_cat[i] = load ? ld_cat[i] : pend_cat[i];
      act_blk = load ? blink : pend_blk;
      if (mf == B - 1) begin
        mf = 0;
        mp = ~mp;
      end else begin
        mf++;
      end
    end
    if (load) begin
      for (int i = 0; i < 4; i++) pend_cat[i] = ld_cat[i];
      pend_blk = blink;
    end
    if (ms == R - 1) begin
      ms = 0;
      mi = (mi + 1) % N;
    end else begin
      ms++;
    end
    @(negedge clk);
    chk("an", {3'b0, an}, {3'b0, e_an});
    chk("cat", cat, e_cat);
    chk("frame_done", {6'b0, fd}, {6'b0, bnd});
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_load(input logic [23:0] d, input logic [3:0] bl,
                         input logic [6:0] g0, input logic [6:0] g1,
                         input logic [6:0] g2, input logic [6:0] g3);
    data = d;
    blink = bl;
    ld_cat[0] = g0; ld_cat[1] = g1; ld_cat[2] = g2; ld_cat[3] = g3;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  // Advance until the next cycle is the frame boundary
  task automatic to_boundary();
    for (int i = 0; i < 40; i++) begin
      if (ms == R - 1 && mi == N - 1) break;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; blink = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_an", {3'b0, an}, 7'h0F);
    chk("rst_cat", cat, 7'h7F);
    chk("rst_fd", {6'b0, fd}, 7'h00);
    rst = 1'b0;

    // Blank display, anodes walking with dead time, frame_done every 32 cycles
    run(32);

    // Mid-frame load: spade, diamond, ace, hex 5; visible only after the boundary
    run(10);
    do_load({6'h05, 6'h21, 6'h10, 6'h13}, 4'b0000, 7'h12, 7'h21, 7'h08, 7'h12);
    run(60);

    // Blink digit 1
    do_load({6'h05, 6'h21, 6'h10, 6'h13}, 4'b0010, 7'h12, 7'h21, 7'h08, 7'h12);
    run(32 * 5);

    // Two loads before a boundary: the second wins (A: hex 0..3, B: K q J 10)
    run(5);
    do_load({6'h03, 6'h02, 6'h01, 6'h00}, 4'b0000, 7'h40, 7'h79, 7'h24, 7'h30);
    run(3);
    do_load({6'h2A, 6'h2B, 6'h2C, 6'h2D}, 4'b0000, 7'h09, 7'h18, 7'h61, 7'h40);
    to_boundary();
    run(33);
    // Load on the boundary cycle itself: heart, club, rank dash, blank
    to_boundary();
    do_load({6'h30, 6'h20, 6'h12, 6'h11}, 4'b0000, 7'h0B, 7'h27, 7'h3F, 7'h7F);
    run(32);

    // Hex A, b, F and rank 7
    run(4);
    do_load({6'h27, 6'h0F, 6'h0B, 6'h0A}, 4'b0000, 7'h08, 7'h03, 7'h0E, 7'h78);
    run(64);

    // Reset mid-slot on digit 2
    for (int i = 0; i < 40; i++) begin
      if (mi == 2 && ms == 4) break;
      cyc();
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_an", {3'b0, an}, 7'h0F);
    chk("midrst_cat", cat, 7'h7F);
    chk("midrst_fd", {6'b0, fd}, 7'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
